mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the instruction-fetch requester (read-only) and the data load/store requester of the pipelined core.
- Holds one transaction outstanding at a time, with registered grant and response sequencing.
- Data requests have priority; a streak limit stops data traffic from starving fetch.
- A response timeout and a fetch-flush for taken branches close out stuck or dead transactions.

---
 rtl/mem_port_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data load/store.
// One transaction in flight; data has priority, bounded by a streak limit so fetch is never starved.
module mem_port_arbiter #(
   parameter int MAX_D_STREAK = 4,
   parameter int TIMEOUT      = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   input  logic        i_flush,
   output logic        i_gnt,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,
   output logic        i_err,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_be,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        d_err,
   output logic        m_req,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_be,
   input  logic        m_ack,
   input  logic [31:0] m_rdata
);

   localparam int            TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
   localparam logic          TMO_EN     = (TIMEOUT != 32'sd0);
   localparam logic [3:0]    STREAK_MAX = 4'(MAX_D_STREAK);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic          r_m_req;
   logic          r_m_we;
   logic [31:0]   r_m_addr;
   logic [31:0]   r_m_wdata;
   logic [3:0]    r_m_be;
   logic          r_own_i;
   logic          r_flush_pend;
   logic [3:0]    r_streak;
   logic [TW-1:0] r_tmo;
   logic          r_i_rvalid;
   logic [31:0]   r_i_rdata;
   logic          r_i_err;
   logic          r_d_rvalid;
   logic [31:0]   r_d_rdata;
   logic          r_d_err;
   logic          w_fetch_ok;
   logic          w_pick_d;
   logic          w_pick_i;
   logic          w_tmo_hit;
   logic          w_done;
   logic          w_i_dead;

   // Arbitration, completion detection and next-state selection
   always_comb begin
      w_fetch_ok = i_req & ~i_flush;
      w_pick_d   = 1'b0;
      w_pick_i   = 1'b0;
      w_tmo_hit  = 1'b0;
      w_done     = 1'b0;
      w_next     = r_state;
      case (r_state)
         S_IDLE: begin
            w_pick_d = d_req & ~(w_fetch_ok & (r_streak == STREAK_MAX));
            w_pick_i = ~w_pick_d & w_fetch_ok;
            if (w_pick_d | w_pick_i) begin
               w_next = S_BUSY;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_BUSY: begin
            // m_ack wins over a timeout landing in the same cycle
            w_tmo_hit = TMO_EN & (r_tmo == TMO_LAST) & ~m_ack;
            w_done    = m_ack | w_tmo_hit;
            if (w_done) begin
               w_next = S_RESP;
            end else begin
               w_next = S_BUSY;
            end
         end
         S_RESP:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   assign w_i_dead = r_flush_pend | i_flush;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Request capture, streak/timeout counters and response registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_m_req      <= 1'b0;
         r_m_we       <= 1'b0;
         r_m_addr     <= 32'h0;
         r_m_wdata    <= 32'h0;
         r_m_be       <= 4'h0;
         r_own_i      <= 1'b0;
         r_flush_pend <= 1'b0;
         r_streak     <= 4'd0;
         r_tmo        <= '0;
         r_i_rvalid   <= 1'b0;
         r_i_rdata    <= 32'h0;
         r_i_err      <= 1'b0;
         r_d_rvalid   <= 1'b0;
         r_d_rdata    <= 32'h0;
         r_d_err      <= 1'b0;
      end else begin
         r_i_rvalid <= 1'b0;
         r_i_rdata  <= 32'h0;
         r_i_err    <= 1'b0;
         r_d_rvalid <= 1'b0;
         r_d_rdata  <= 32'h0;
         r_d_err    <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_flush_pend <= 1'b0;
               r_tmo        <= '0;
               if (w_pick_d) begin
                  r_own_i   <= 1'b0;
                  r_m_req   <= 1'b1;
                  r_m_we    <= d_we;
                  r_m_addr  <= d_addr;
                  r_m_wdata <= d_wdata;
                  r_m_be    <= d_be;
                  r_streak  <= w_fetch_ok ? ((r_streak == STREAK_MAX) ? r_streak : r_streak + 4'd1)
                                          : 4'd0;
               end else if (w_pick_i) begin
                  r_own_i   <= 1'b1;
                  r_m_req   <= 1'b1;
                  r_m_we    <= 1'b0;
                  r_m_addr  <= i_addr;
                  r_m_wdata <= 32'h0;
                  r_m_be    <= 4'hF;
                  r_streak  <= 4'd0;
               end else begin
                  r_m_req   <= 1'b0;
               end
            end
            S_BUSY: begin
               if (i_flush & r_own_i) begin
                  r_flush_pend <= 1'b1;
               end
               if (w_done) begin
                  r_m_req <= 1'b0;
                  if (r_own_i) begin
                     r_i_rvalid <= ~w_i_dead;
                     r_i_rdata  <= (m_ack & ~w_i_dead) ? m_rdata : 32'h0;
                     r_i_err    <= w_tmo_hit & ~w_i_dead;
                  end else begin
                     r_d_rvalid <= 1'b1;
                     r_d_rdata  <= (m_ack & ~r_m_we) ? m_rdata : 32'h0;
                     r_d_err    <= w_tmo_hit;
                  end
               end else begin
                  r_tmo <= r_tmo + TW'(1);
               end
            end
            S_RESP: begin
               r_m_req <= 1'b0;
            end
            default: begin
               r_m_req <= 1'b0;
            end
         endcase
      end
   end

   assign i_gnt    = w_pick_i;
   assign d_gnt    = w_pick_d;
   // A flush arriving while the fetch response is presented still kills it
   assign i_rvalid = r_i_rvalid & ~i_flush;
   assign i_rdata  = r_i_rdata;
   assign i_err    = r_i_err & ~i_flush;
   assign d_rvalid = r_d_rvalid;
   assign d_rdata  = r_d_rdata;
   assign d_err    = r_d_err;
   assign m_req    = r_m_req;
   assign m_we     = r_m_we;
   assign m_addr   = r_m_addr;
   assign m_wdata  = r_m_wdata;
   assign m_be     = r_m_be;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter with a memory responder and
// a transaction-level reference model (grant rule, streak count, shadow memory).
module tb_mem_port_arbiter;

   localparam int          MAXS  = 4;
   localparam int          TMO   = 8;
   localparam logic [31:0] BASE  = 32'h0000_2000;
   localparam logic [9:0]  ORDER = 10'b10_0001_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, i_flush, i_gnt, i_rvalid, i_err;
   logic [31:0] i_addr, i_rdata;
   logic        d_req, d_we, d_gnt, d_rvalid, d_err;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [3:0]  d_be;
   logic        m_req, m_we, m_ack;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [3:0]  m_be;

   int vecs = 0;
   int errs = 0;
   int streak_m;
   logic [31:0] mem     [16];
   logic [31:0] ref_mem [16];

   always #5 clk = ~clk;

   mem_port_arbiter #(.MAX_D_STREAK(MAXS), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_gnt(i_gnt),
      .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_err(i_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
      .m_ack(m_ack), .m_rdata(m_rdata)
   );

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      i_req = 1'b0; i_addr = 32'h0; i_flush = 1'b0;
      d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'h0;
      m_ack = 1'b0; m_rdata = 32'h0;
   endtask

   task automatic expect_grant(input string tag, input logic ei, input logic ed);
      #1;
      chk1({tag, "_i_gnt"}, i_gnt, ei);
      chk1({tag, "_d_gnt"}, d_gnt, ed);
   endtask

   // Memory side of one BUSY phase: lat idle cycles, then the ack cycle.
   task automatic serve(input string tag, input int lat, input logic use_mem,
                        input logic [31:0] rdat, input logic [31:0] ea, input logic ewe,
                        input logic [3:0] ebe, input logic [31:0] ewd, input int flush_at);
      for (int k = 0; k <= lat; k++) begin
         @(negedge clk);
         i_flush = (k == flush_at);
         m_ack   = (k == lat);
         m_rdata = 32'h0;
         if (k == lat) begin
            if (use_mem) begin
               m_rdata = mem[m_addr[5:2]];
               if (m_we) mem[m_addr[5:2]] = merge(mem[m_addr[5:2]], m_wdata, m_be);
            end else begin
               m_rdata = rdat;
            end
         end
         #1;
         chk1({tag, "_mreq"}, m_req, 1'b1);
         chk1({tag, "_busy_nognt"}, i_gnt | d_gnt, 1'b0);
         if (k == 0) begin
            chk({tag, "_maddr"}, m_addr, ea);
            chk1({tag, "_mwe"}, m_we, ewe);
            chk({tag, "_mbe"}, 32'(m_be), 32'(ebe));
            if (ewe) chk({tag, "_mwdata"}, m_wdata, ewd);
         end
      end
      @(negedge clk);
      m_ack = 1'b0; m_rdata = 32'h0; i_flush = 1'b0;
   endtask

   task automatic chk_resp(input string tag, input logic ei, input logic ed,
                           input logic [31:0] erd, input logic eerr);
      #1;
      chk1({tag, "_i_rvalid"}, i_rvalid, ei);
      chk1({tag, "_d_rvalid"}, d_rvalid, ed);
      if (ei) begin
         chk({tag, "_i_rdata"}, i_rdata, erd);
         chk1({tag, "_i_err"}, i_err, eerr);
      end
      if (ed) begin
         chk({tag, "_d_rdata"}, d_rdata, erd);
         chk1({tag, "_d_err"}, d_err, eerr);
      end
   endtask

   // Both requesters held for n grants with immediate acks; checks the D/I order.
   task automatic held_grants(input string tag, input int n);
      logic [9:0]  obs;
      logic [9:0]  exp_o;
      logic        ei;
      logic [31:0] rd;
      obs   = 10'h0;
      exp_o = ORDER & 10'((1 << n) - 1);
      for (int g = 0; g < n; g++) begin
         @(negedge clk);
         if (g == 0) begin
            i_req = 1'b1; i_addr = 32'h300;
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1008; d_be = 4'hF;
         end
         #1;
         obs[g] = i_gnt;
         chk1({tag, "_onehot"}, i_gnt ^ d_gnt, 1'b1);
         ei = ORDER[g];
         rd = $urandom;
         serve(tag, 0, 1'b0, rd, ei ? 32'h300 : 32'h1008, 1'b0, 4'hF, 32'h0, -1);
         chk_resp(tag, ei, ~ei, rd, 1'b0);
      end
      i_req = 1'b0; d_req = 1'b0;
      chk({tag, "_order"}, 32'(obs), 32'(exp_o));
   endtask

   initial begin
      int          hi;
      logic        pi, pd, pd_we, win_i, win_d, ewe;
      int          pi_idx, pd_idx;
      logic [31:0] pd_wd, ea, ewd, erd;
      logic [3:0]  pd_be, ebe;

      rst = 1'b1;
      idle_inputs();
      repeat (2) @(negedge clk);
      #1;
      chk1("rst_mreq", m_req, 1'b0);
      chk("rst_maddr", m_addr, 32'h0);
      chk("rst_mwdata", m_wdata, 32'h0);
      chk("rst_ctl", {25'h0, i_gnt, d_gnt, i_rvalid, d_rvalid, i_err, d_err, m_we}, 32'h0);
      chk("rst_mbe", 32'(m_be), 32'h0);
      chk("rst_rdata", i_rdata | d_rdata, 32'h0);
      rst = 1'b0;

      // single fetch, minimum latency
      @(negedge clk);
      i_req = 1'b1; i_addr = 32'h100;
      expect_grant("fetch1", 1'b1, 1'b0);
      @(posedge clk); #1; i_req = 1'b0;
      serve("fetch1", 0, 1'b0, 32'hDEADBEEF, 32'h100, 1'b0, 4'hF, 32'h0, -1);
      chk_resp("fetch1", 1'b1, 1'b0, 32'hDEADBEEF, 1'b0);

      // contention: store wins, then the held fetch
      @(negedge clk);
      i_req = 1'b1; i_addr = 32'h200;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1004; d_wdata = 32'h55AA1234; d_be = 4'b0011;
      expect_grant("cont_st", 1'b0, 1'b1);
      @(posedge clk); #1; d_req = 1'b0;
      serve("cont_st", 1, 1'b0, 32'hFFFFFFFF, 32'h1004, 1'b1, 4'b0011, 32'h55AA1234, -1);
      chk_resp("cont_st", 1'b0, 1'b1, 32'h0, 1'b0);
      @(negedge clk);
      expect_grant("cont_if", 1'b1, 1'b0);
      @(posedge clk); #1; i_req = 1'b0;
      serve("cont_if", 0, 1'b0, 32'h12345678, 32'h200, 1'b0, 4'hF, 32'h0, -1);
      chk_resp("cont_if", 1'b1, 1'b0, 32'h12345678, 1'b0);

      held_grants("starve", 10);

      // timeout on a load that is never acked
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100C; d_be = 4'hF;
      expect_grant("tmo", 1'b0, 1'b1);
      @(posedge clk); #1; d_req = 1'b0;
      hi = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk); #1;
         if (!m_req) break;
         hi++;
      end
      chk("tmo_mreq_cycles", 32'(hi), 32'd8);
      chk1("tmo_d_rvalid", d_rvalid, 1'b1);
      chk1("tmo_d_err", d_err, 1'b1);
      chk("tmo_d_rdata", d_rdata, 32'h0);
      chk1("tmo_i_rvalid", i_rvalid, 1'b0);
      @(negedge clk);
      d_req = 1'b1; d_addr = 32'h1014;
      expect_grant("tmo_after", 1'b0, 1'b1);
      @(posedge clk); #1; d_req = 1'b0;
      serve("tmo_after", 0, 1'b0, 32'hCAFEF00D, 32'h1014, 1'b0, 4'hF, 32'h0, -1);
      chk_resp("tmo_after", 1'b0, 1'b1, 32'hCAFEF00D, 1'b0);

      // flush during a fetch in BUSY
      @(negedge clk);
      i_req = 1'b1; i_addr = 32'h400;
      expect_grant("flush", 1'b1, 1'b0);
      @(posedge clk); #1; i_req = 1'b0;
      serve("flush", 2, 1'b0, 32'h0BADF00D, 32'h400, 1'b0, 4'hF, 32'h0, 0);
      chk_resp("flush", 1'b0, 1'b0, 32'h0, 1'b0);
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1018; d_be = 4'hF;
      #1;
      chk1("flush_resp_nognt", d_gnt, 1'b0);
      @(negedge clk);
      expect_grant("flush_d", 1'b0, 1'b1);
      @(posedge clk); #1; d_req = 1'b0;
      serve("flush_d", 0, 1'b0, 32'h13572468, 32'h1018, 1'b0, 4'hF, 32'h0, -1);
      chk_resp("flush_d", 1'b0, 1'b1, 32'h13572468, 1'b0);
      @(negedge clk);
      i_req = 1'b1; i_addr = 32'h404; i_flush = 1'b1;
      expect_grant("flush_idle1", 1'b0, 1'b0);
      @(negedge clk);
      expect_grant("flush_idle2", 1'b0, 1'b0);
      @(negedge clk);
      i_flush = 1'b0;
      expect_grant("flush_rel", 1'b1, 1'b0);
      @(posedge clk); #1; i_req = 1'b0;
      serve("flush_rel", 0, 1'b0, 32'h24681357, 32'h404, 1'b0, 4'hF, 32'h0, -1);
      chk_resp("flush_rel", 1'b1, 1'b0, 32'h24681357, 1'b0);

      // reset in the middle of a data transaction, streak at 2
      @(negedge clk);
      i_req = 1'b1; i_addr = 32'h500;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1010; d_be = 4'hF;
      expect_grant("rst_pre1", 1'b0, 1'b1);
      serve("rst_pre1", 0, 1'b0, 32'hA5A5A5A5, 32'h1010, 1'b0, 4'hF, 32'h0, -1);
      chk_resp("rst_pre1", 1'b0, 1'b1, 32'hA5A5A5A5, 1'b0);
      @(negedge clk);
      expect_grant("rst_pre2", 1'b0, 1'b1);
      @(negedge clk); #1;
      chk1("rst_pre_mreq", m_req, 1'b1);
      #1; rst = 1'b1;
      #1;
      chk1("rst_async_mreq", m_req, 1'b0);
      i_req = 1'b0; d_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) begin
         @(negedge clk); #1;
         chk("rst_no_rvalid", {30'h0, i_rvalid, d_rvalid}, 32'h0);
      end
      held_grants("post_rst", 5);

      // randomized traffic against the reference model
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      streak_m = 0;
      for (int i = 0; i < 16; i++) begin
         mem[i]     = $urandom;
         ref_mem[i] = mem[i];
      end
      pi = 1'b0; pd = 1'b0; pi_idx = 0; pd_idx = 0;
      pd_we = 1'b0; pd_wd = 32'h0; pd_be = 4'h0;
      for (int t = 0; t < 60; t++) begin
         @(negedge clk);
         if (!pi && ($urandom_range(0, 2) != 0)) begin
            pi = 1'b1; pi_idx = $urandom_range(0, 15);
         end
         if (!pd && ($urandom_range(0, 2) != 0)) begin
            pd = 1'b1; pd_idx = $urandom_range(0, 15);
            pd_we = 1'($urandom_range(0, 1)); pd_wd = $urandom; pd_be = 4'($urandom_range(0, 15));
         end
         if (!pi && !pd) begin
            pi = 1'b1; pi_idx = $urandom_range(0, 15);
         end
         i_req = pi; i_addr = BASE + 32'(pi_idx * 4);
         d_req = pd; d_we = pd_we; d_addr = BASE + 32'(pd_idx * 4); d_wdata = pd_wd; d_be = pd_be;
         win_d = pd && !(pi && (streak_m == MAXS));
         win_i = !win_d && pi;
         expect_grant("rnd", win_i, win_d);
         if (win_d) begin
            ea = d_addr; ebe = pd_be; ewe = pd_we; ewd = pd_wd;
            erd = pd_we ? 32'h0 : ref_mem[pd_idx];
            if (pd_we) ref_mem[pd_idx] = merge(ref_mem[pd_idx], pd_wd, pd_be);
            streak_m = pi ? ((streak_m < MAXS) ? streak_m + 1 : MAXS) : 0;
         end else begin
            ea = i_addr; ebe = 4'hF; ewe = 1'b0; ewd = 32'h0;
            erd = ref_mem[pi_idx];
            streak_m = 0;
         end
         @(posedge clk); #1;
         if (win_d) begin
            pd = 1'b0; d_req = 1'b0;
         end else begin
            pi = 1'b0; i_req = 1'b0;
         end
         serve("rnd", $urandom_range(0, 3), 1'b1, 32'h0, ea, ewe, ebe, ewd, -1);
         chk_resp("rnd", win_i, win_d, erd, 1'b0);
      end
      i_req = 1'b0; d_req = 1'b0;
      for (int i = 0; i < 16; i++) begin
         chk("rnd_mem_final", mem[i], ref_mem[i]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
